// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S DAC transmitter: stereo sample FIFO, BCLK/LRCK generation, MSB-first serializer.
module i2s_dac_tx #(
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_val,
    input  logic [31:0]                   sample_data,
    output logic                          aud_bclk,
    output logic                          aud_daclrck,
    output logic                          aud_dacdat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic          lrck_q, lrck_d;
    logic          dat_q, dat_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   frame_reg_q, frame_reg_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   mem_d [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underrun_q, underrun_d;

    logic          div_wrap, bclk_fall, frame_wrap;
    logic          fifo_empty, fifo_full, push, pop;
    logic [4:0]    slot_pos;
    logic [3:0]    bit_idx;
    logic [15:0]   ch;

    always_comb begin
        div_cnt_d   = div_cnt_q;
        bclk_d      = bclk_q;
        lrck_d      = lrck_q;
        dat_d       = dat_q;
        bit_cnt_d   = bit_cnt_q;
        frame_reg_d = frame_reg_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        slot_pos    = '0;
        bit_idx     = '0;
        ch          = '0;

        div_wrap  = (div_cnt_q == DW'(BCLK_DIV - 1));
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        if (div_wrap) begin
            bclk_d = ~bclk_q;
        end
        bclk_fall  = div_wrap & bclk_q;
        frame_wrap = bclk_fall & (bit_cnt_q == 6'd63);

        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // No bypass: a pop only sees entries present before this clk.
        pop  = frame_wrap & ~fifo_empty;
        push = sample_val & (~fifo_full | pop);

        if (pop) begin
            frame_reg_d = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d    = rd_ptr_q + 1'b1;
        end
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = sample_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end

        if (bclk_fall) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            lrck_d    = bit_cnt_d[5];
            slot_pos  = bit_cnt_d[4:0];
            ch        = bit_cnt_d[5] ? frame_reg_d[15:0] : frame_reg_d[31:16];
            // Slot position 1 carries the MSB: one BCLK of I2S delay after LRCK.
            bit_idx   = 4'(5'd16 - slot_pos);
            dat_d     = (slot_pos >= 5'd1 && slot_pos <= 5'd16) ? ch[bit_idx] : 1'b0;
        end

        level_d    = wr_ptr_d - rd_ptr_d;
        overflow_d = sample_val & ~push;
        underrun_d = frame_wrap & fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            dat_q       <= 1'b0;
            bit_cnt_q   <= '0;
            frame_reg_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            dat_q       <= dat_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_reg_q <= frame_reg_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underrun_q  <= underrun_d;
        end
    end

    assign aud_bclk    = bclk_q;
    assign aud_daclrck = lrck_q;
    assign aud_dacdat  = dat_q;
    assign fifo_level  = level_q;
    assign overflow    = overflow_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - Directed bench for i2s_dac_tx with BCLK_DIV=2, FIFO_DEPTH=4.
module tb_i2s_dac_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_val;
    logic [31:0] sample_data;
    logic        aud_bclk, aud_daclrck, aud_dacdat;
    logic [2:0]  fifo_level;
    logic        overflow, underrun;

    always #5 clk = ~clk;

    i2s_dac_tx #(.BCLK_DIV(2), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_val  (sample_val),
        .sample_data (sample_data),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .underrun    (underrun)
    );

    typedef struct {
        logic [31:0] word;
        int          level;
        int          urn_delta;
    } frame_vec_t;

    frame_vec_t  tbl [5];
    int          checks   = 0;
    int          failures = 0;
    logic        pb, plr, pd, bfall, lrfall, mon_en;
    int          viol, ovf_cnt, urn_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for DUT event", name);
    endtask

    task automatic resync();
        pb  = aud_bclk;
        plr = aud_daclrck;
        pd  = aud_dacdat;
    endtask

    task automatic step();
        @(negedge clk);
        bfall  = pb && !aud_bclk;
        lrfall = plr && !aud_daclrck;
        if (mon_en) begin
            if ((aud_dacdat != pd || aud_daclrck != plr) && !bfall) viol++;
            if (overflow) ovf_cnt++;
            if (underrun) urn_cnt++;
        end
        resync();
    endtask

    task automatic wait_frame(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (lrfall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    // Assumes the current sample is the frame-start falling BCLK.
    task automatic capture(output logic [63:0] bits);
        bit ok;
        bits    = '0;
        bits[0] = aud_dacdat;
        for (int k = 1; k < 64; k++) begin
            ok = 1'b0;
            for (int j = 0; j < 20; j++) begin
                step();
                if (bfall) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                timeout("capture_bclk");
                return;
            end
            bits[k] = aud_dacdat;
        end
    endtask

    function automatic logic [63:0] frame_exp(input logic [31:0] w);
        logic [63:0] e = '0;
        for (int p = 1; p <= 16; p++) begin
            e[p]      = w[32 - p];
            e[32 + p] = w[16 - p];
        end
        return e;
    endfunction

    function automatic logic [31:0] wv(input int k);
        return {16'hA000 | 16'(k), 16'h5000 | 16'(k)};
    endfunction

    logic [63:0] bits;
    int          bad, n, nb, first, cyc_n, urn0, ovf0;

    initial begin
        tbl[0] = '{wv(1), 3, 0};
        tbl[1] = '{wv(2), 2, 0};
        tbl[2] = '{wv(3), 1, 0};
        tbl[3] = '{wv(4), 0, 0};
        tbl[4] = '{wv(4), 0, 1};

        mon_en = 1'b0; viol = 0; ovf_cnt = 0; urn_cnt = 0;
        rst_n = 1'b0; sample_val = 1'b0; sample_data = 32'h1234_5678;

        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sample_val = ~sample_val;
            if ({aud_bclk, aud_daclrck, aud_dacdat, fifo_level, overflow, underrun} != '0) bad++;
        end
        check("reset_outputs", 64'(bad), 0);
        sample_val = 1'b0;
        rst_n = 1'b1;
        resync();
        mon_en = 1'b1;

        step();
        check("level_after_reset", 64'(fifo_level), 0);
        sample_val = 1'b1; sample_data = 32'hABCD_1234;
        step();
        sample_val = 1'b0;
        check("level_after_push", 64'(fifo_level), 1);

        bad = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (lrfall) break;
            if (aud_dacdat) bad++;
        end
        check("frame0_zero", 64'(bad), 0);
        check("frame1_no_underrun", 64'(urn_cnt), 0);
        capture(bits);
        check("frame1_data", bits, frame_exp(32'hABCD_1234));

        wait_frame("frame2_start");
        cyc_n = 0; nb = 0; first = -1;
        for (int i = 0; i < 400; i++) begin
            step();
            cyc_n++;
            if (bfall) begin
                nb++;
                if (first < 0) first = cyc_n;
            end
            if (lrfall) break;
        end
        check("bclk_period", 64'(first), 4);
        check("lrck_period_bclks", 64'(nb), 64);
        check("lrck_period_clks", 64'(cyc_n), 256);

        check("underrun_count_f3", 64'(urn_cnt), 2);
        capture(bits);
        check("frame3_repeat", bits, frame_exp(32'hABCD_1234));
        wait_frame("frame4_start");
        check("underrun_count_f4", 64'(urn_cnt), 3);
        capture(bits);
        check("frame4_repeat", bits, frame_exp(32'hABCD_1234));
        check("underrun_once_per_frame", 64'(urn_cnt), 3);

        wait_frame("frame5_start");
        repeat (20) step();
        for (int k = 1; k <= 5; k++) begin
            sample_val = 1'b1; sample_data = wv(k);
            step();
        end
        sample_val = 1'b0;
        check("overflow_level", 64'(fifo_level), 4);
        check("overflow_pulse", 64'(ovf_cnt), 1);
        repeat (3) step();
        check("overflow_single", 64'(ovf_cnt), 1);

        urn0 = urn_cnt;
        for (int i = 0; i < 5; i++) begin
            wait_frame("tbl_frame_start");
            check($sformatf("tbl%0d_level", i), 64'(fifo_level), 64'(tbl[i].level));
            check($sformatf("tbl%0d_underrun", i), 64'(urn_cnt - urn0), 64'(tbl[i].urn_delta));
            capture(bits);
            check($sformatf("tbl%0d_data", i), bits, frame_exp(tbl[i].word));
        end

        wait_frame("full_pop_start");
        ovf0 = ovf_cnt;
        for (int s = 1; s <= 255; s++) begin
            step();
            if (s == 254) check("full_before_wrap", 64'(fifo_level), 4);
            sample_val  = (s >= 10 && s <= 13) || s == 255;
            sample_data = (s == 255) ? 32'hFEED_0F0F : wv(s + 6);
        end
        step();
        sample_val = 1'b0;
        check("full_pop_on_wrap", 64'(lrfall), 1);
        check("full_pop_level", 64'(fifo_level), 4);
        check("full_pop_no_overflow", 64'(ovf_cnt - ovf0), 0);
        capture(bits);
        check("full_pop_data", bits, frame_exp(wv(16)));

        repeat (50) step();
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs",
                 64'({aud_bclk, aud_daclrck, aud_dacdat, fifo_level, overflow, underrun}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        resync();
        mon_en = 1'b1;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            n++;
            if (aud_daclrck) break;
        end
        check("restart_left_slot_len", 64'(n), 128);
        check("restart_level", 64'(fifo_level), 0);

        wait_frame("empty_pop_start");
        urn0 = urn_cnt;
        for (int s = 1; s <= 255; s++) begin
            step();
            sample_val  = (s == 255);
            sample_data = 32'h7E57_C0DE;
        end
        step();
        sample_val = 1'b0;
        check("empty_pop_on_wrap", 64'(lrfall), 1);
        check("empty_pop_underrun", 64'(urn_cnt - urn0), 1);
        check("empty_pop_level", 64'(fifo_level), 1);
        wait_frame("empty_pop_next");
        capture(bits);
        check("empty_pop_data", bits, frame_exp(32'h7E57_C0DE));

        check("lr_dat_only_on_bclk_fall", 64'(viol), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
